// File: rtl/noc_rr_arbiter.sv
// Packet-locking round-robin arbiter for a NoC output port: registered one-hot grant,
// held until tail/withdraw. Optional forced release on stall when NOC_ARB_TIMEOUT_EN is defined.
module noc_rr_arbiter #(
  parameter int N              = 5,
  parameter int IDX_W          = $clog2(N),
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N-1:0]     req,
  input  logic [N-1:0]     last,
  input  logic             ready,
  output logic [N-1:0]     grant,
  output logic             grant_valid,
  output logic [IDX_W-1:0] grant_idx,
  output logic             timeout
);

  // state  | meaning
  // IDLE   | no grant held; next edge grants first requester at or after ptr
  // LOCKED | grant held for grant_idx until tail transfer, withdraw or timeout
  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

  localparam logic [N-1:0] ONE_HOT0 = N'(1);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [N-1:0]     grant_q, grant_d;
  logic [IDX_W-1:0] win;
  logic             found;
  logic             xfer;
  logic             rel_pkt;
  logic             do_release;

`ifdef NOC_ARB_TIMEOUT_EN
  logic [15:0] stall_q, stall_d;
  logic        timeout_q, timeout_d;
`else
  logic [15:0] unused_timeout_cfg;
  assign unused_timeout_cfg = 16'(TIMEOUT_CYCLES);
`endif

  // Rotating priority search starting at ptr, wrapping modulo N (N need not be a power of 2).
  always_comb begin
    win   = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      int p;
      p = int'(ptr_q) + k;
      if (p >= N) p = p - N;
      if (!found && req[IDX_W'(p)]) begin
        found = 1'b1;
        win   = IDX_W'(p);
      end
    end
  end

  assign xfer    = (state_q == LOCKED) && req[idx_q] && ready;
  assign rel_pkt = !req[idx_q] || (xfer && last[idx_q]);

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    idx_d      = idx_q;
    grant_d    = grant_q;
    do_release = 1'b0;
`ifdef NOC_ARB_TIMEOUT_EN
    stall_d    = stall_q;
    timeout_d  = 1'b0;
`endif
    if (state_q == IDLE) begin
      if (found) begin
        grant_d = ONE_HOT0 << win;
        idx_d   = win;
        state_d = LOCKED;
      end
    end else begin
      do_release = rel_pkt;
`ifdef NOC_ARB_TIMEOUT_EN
      if (rel_pkt || xfer) begin
        stall_d = '0;
      end else if (stall_q == 16'(TIMEOUT_CYCLES - 1)) begin
        do_release = 1'b1;
        timeout_d  = 1'b1;
        stall_d    = '0;
      end else begin
        stall_d = stall_q + 16'd1;
      end
`endif
    end
    if (do_release) begin
      grant_d = '0;
      idx_d   = '0;
      state_d = IDLE;
      ptr_d   = (idx_q == IDX_W'(N - 1)) ? '0 : idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      idx_q     <= '0;
      grant_q   <= '0;
`ifdef NOC_ARB_TIMEOUT_EN
      stall_q   <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      idx_q     <= idx_d;
      grant_q   <= grant_d;
`ifdef NOC_ARB_TIMEOUT_EN
      stall_q   <= stall_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  assign grant       = grant_q;
  assign grant_valid = |grant_q;
  assign grant_idx   = idx_q;
`ifdef NOC_ARB_TIMEOUT_EN
  assign timeout     = timeout_q;
`else
  assign timeout     = 1'b0;
`endif

endmodule

// File: doc/noc_rr_arbiter.md
# noc_rr_arbiter

Parametrised, packet-locking round-robin arbiter for the NoC router output stage. It selects one of N input-port requesters and issues a registered one-hot grant. The grant is held for the whole packet, until the tail flit transfers or the requester withdraws. Priority then rotates to the port after the last winner. One instance sits in front of each router output port's crossbar mux.

## Interface
- `N`, 5, number of requesters (legal range 2..16).
- `IDX_W`, `$clog2(N)`, width of `grant_idx`. Derived; do not override.
- `TIMEOUT_CYCLES`, 64, stall cycles before a forced release. Used only when `NOC_ARB_TIMEOUT_EN` is defined; legal range 2..65535.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req`  in  N  per-port request; bit i means port i has a flit ready for this output.
- `last`  in  N  per-port tail-flit marker; meaningful only while `req[i]`=1.
- `ready`  in  1  downstream accepts a flit this cycle.
- `grant`  out  N  registered one-hot grant; all-zero when idle.
- `grant_valid`  out  1  OR-reduction of `grant`.
- `grant_idx`  out  IDX_W  binary index of the granted port; 0 when idle.
- `timeout`  out  1  one-cycle pulse on a forced release; constant 0 when timeout is compiled out.

## Operation
- State: `state` (IDLE/LOCKED), `ptr` (IDX_W, highest-priority port), `grant`/`grant_idx` registers.
- Transfer, `xfer` = `grant_valid & req[grant_idx] & ready`.
- IDLE behaviour:
  - If `req`=0, nothing changes.
  - Otherwise the winner w is the first set bit of `req`, searching ptr, ptr+1, … wrapping modulo N.
  - At the edge: `grant`=1<<w, `grant_idx`=w, state goes to LOCKED.
  - `ptr` is not changed in IDLE.
- LOCKED behaviour, with g = `grant_idx`; priority order:
  1. `req[g]`=0 (withdraw): release; `ptr`=(g+1) mod N.
  2. `xfer & last[g]` (tail): release; `ptr`=(g+1) mod N.
  3. Timeout expiry (macro builds only): release; `ptr`=(g+1) mod N; `timeout`=1 for the next cycle.
  4. Otherwise: hold the grant.
- "Release" means: `grant`=0, `grant_idx`=0, state goes to IDLE.
- `ptr` wrap-around: g=N-1 gives `ptr`=0. This applies for non-power-of-2 N too.
- Requests from other ports while LOCKED are ignored; `req` changes never alter the held grant except by withdraw.
- `last` on a non-granted port is ignored. `last` without `ready` does not release.
- Reset values: `grant`=0, `grant_valid`=0, `grant_idx`=0, `timeout`=0, state IDLE, `ptr`=0, timeout counter 0.
- Reset mid-packet drops the grant immediately (asynchronous); no `timeout` pulse is produced.

## Timing
- Request-to-grant latency: 1 cycle. `req` seen in cycle t gives the grant visible in cycle t+1.
- `grant` is fully registered; no combinational path from `req`/`ready` to `grant`.
- Release edge: the tail transfers in cycle t, so `grant`=0 in t+1 and the next grant appears in t+2.
  - This is one mandatory idle bubble between packets, even when the same port re-requests.
- A single-flit packet (`last`=1 on first transfer) holds the grant for exactly one cycle when `ready`=1.
- Withdraw takes effect at the next edge, identically to a tail release.

## Configuration
- `NOC_ARB_TIMEOUT_EN` defined:
  - A 16-bit stall counter runs in LOCKED.
  - It clears on `xfer` and on release, and increments on each LOCKED cycle without `xfer`.
  - When the counter equals `TIMEOUT_CYCLES-1` with no `xfer` and no withdraw/tail release in that cycle, the arbiter force-releases at the edge and `timeout` pulses high for exactly one cycle.
- Macro undefined:
  - No counter is built and `timeout` is tied to 0.
  - A stalled grant is held indefinitely until tail or withdraw.

## Test plan
- Reset, N=4: assert `reset` mid-cycle → all outputs 0 asynchronously. Release reset, `req`=4'b0000 for 5 cycles → `grant` stays 0.
- Rotation, N=4: `req`=4'b1111 continuously, `last`=4'b1111, `ready`=1 → `grant` sequence 0001, 0000, 0010, 0000, 0100, 0000, 1000, 0000, 0001.
- Packet lock, N=4: port 1 granted, `ready`=1, `last[1]`=0 for 3 cycles while `req`=4'b1111 → `grant` stays 0010. `last[1]`=1 → 0000 next cycle, then 0100.
- Backpressure and withdraw, N=5: port 4 granted, `ready`=0 with `last[4]`=1 → grant held. Drop `req[4]` → `grant`=0 next cycle; `ptr`=0, so with `req`=5'b10001 the next grant is 00001.
- Timeout (`NOC_ARB_TIMEOUT_EN` defined, `TIMEOUT_CYCLES`=4): port 2 granted, `ready`=0 → after 4 locked cycles `grant`=0 and `timeout`=1 for one cycle, `ptr`=3.
  - Without the macro, the same stimulus for 100 cycles → grant held, `timeout`=0.
